// File: rtl/lc3b_types.sv
// ============================================================================
//  Package     : lc3b_types
//  Description : Shared types for the branch resolve queue: predictor word,
//                2-bit counter value, queue entry and taken-decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_bp_count;

   typedef struct packed {
      lc3b_word     pc;
      lc3b_bp_count count;
   } brq_entry_t;

   // The upper counter bit is the predicted direction.
   function automatic logic bp_taken(input lc3b_bp_count count);
      return count[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_queue_sat_counter.sv
// ============================================================================
//  Module      : brq_sat_counter
//  Description : 16-bit event counter that sticks at 16'hFFFF.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module brq_sat_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [15:0] count
);

   logic [15:0] r_count;

   // Count events, holding once the all-ones value is reached.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 16'h0000;
      end else if (inc && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// ============================================================================
//  Module      : branch_resolve_queue
//  Description : In-order queue of predicted branches. Resolving the oldest
//                entry drives the predictor-table update one cycle later and
//                flags a mispredict, which squashes all younger entries.
//                Optional macro BRQ_STATS_EN adds resolve/mispredict counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_queue
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic [15:0]                alloc_pc,
   input  logic [1:0]                 alloc_count,
   input  logic                       resolve_valid,
   output logic                       resolve_ready,
   input  logic                       resolve_taken,
   input  logic                       flush,
   output logic                       pred_load,
   output logic                       pred_branch_enable,
   output logic [15:0]                pred_index,
   output logic                       mispredict,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef BRQ_STATS_EN
   ,
   output logic [15:0]                stat_resolved,
   output logic [15:0]                stat_mispred
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] C_FULL = OCC_W'(DEPTH);

   brq_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [OCC_W-1:0] r_count;

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_mis;
   brq_entry_t       w_head_entry;
   brq_entry_t       w_new_entry;

   assign w_full        = (r_count == C_FULL);
   assign w_empty       = (r_count == '0);
   assign alloc_ready   = !w_full;
   assign resolve_ready = !w_empty;
   assign occupancy     = r_count;

   assign w_head_entry  = r_mem[r_head];
   assign w_new_entry   = '{pc: alloc_pc, count: alloc_count};

   // Flush overrides everything. A push into a full queue is still legal
   // when the oldest entry leaves on the same edge.
   assign w_pop  = resolve_valid && !w_empty && !flush;
   assign w_push = alloc_valid && (!w_full || w_pop) && !flush;
   assign w_mis  = w_pop && (bp_taken(w_head_entry.count) != resolve_taken);

   // Pointer and occupancy bookkeeping; a mispredict drops every younger
   // entry, including one pushed on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (w_mis) begin
         r_head  <= r_head + PTR_W'(1);
         r_tail  <= r_head + PTR_W'(1);
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
      end
   end

   // Entry storage: plain flops, written at the tail on an accepted push.
   always_ff @(posedge clk) begin
      if (w_push && !w_mis) begin
         r_mem[r_tail] <= w_new_entry;
      end
   end

   // Predictor update strobes, one cycle after the pop; index holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pred_load          <= 1'b0;
         pred_branch_enable <= 1'b0;
         mispredict         <= 1'b0;
         pred_index         <= 16'h0000;
      end else begin
         pred_load          <= w_pop;
         pred_branch_enable <= w_pop && resolve_taken;
         mispredict         <= w_mis;
         if (w_pop) begin
            pred_index <= w_head_entry.pc;
         end
      end
   end

`ifdef BRQ_STATS_EN
   brq_sat_counter u_stat_resolved (
      .clk   (clk),
      .reset (reset),
      .inc   (w_pop),
      .count (stat_resolved)
   );

   brq_sat_counter u_stat_mispred (
      .clk   (clk),
      .reset (reset),
      .inc   (w_mis),
      .count (stat_mispred)
   );
`endif

endmodule

`default_nettype wire
